fpu_fpf_wbq: RTL and testbench
==============================

# fpu_fpf_wbq

Single-precision FPU result writeback queue. Sits directly downstream of the FP multiply stage: each cycle the multiplier asserts `isen`, its 32-bit result and destination register tag are pushed into a small FIFO, which drains one entry per cycle into the FP register-file write port, honouring a stall from that port. It also classifies results into sticky status flags and provides a tag-lookup forwarding path so operand fetch can read results not yet written back.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `TAGW`, 5: destination register tag width.

- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `isen` in 1: push request; multiplier result valid this cycle.
- `idTag` in TAGW: destination register of pushed result.
- `srcVal` in 32: multiplier result (IEEE single).
- `wrStall` in 1: register-file port busy; no pop this cycle.
- `oWrEn` out 1: register-file write strobe (registered).
- `oWrTag` out TAGW: write tag (registered).
- `oWrVal` out 32: write data (registered).
- `oFull` out 1: count == DEPTH; upstream must hold `isen` low.
- `oCount` out log2(DEPTH)+1: current occupancy.
- `lkTag` in TAGW: forwarding lookup tag.
- `oLkHit` out 1: combinational; a pending result for `lkTag` exists.
- `oLkVal` out 32: combinational; that result.
- `clrFlags` in 1: clear sticky flags.
- `oFlags` out 4: sticky [0] zero result, [1] infinity, [2] NaN, [3] overrun.

## Operation
- Circular FIFO: head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; separate occupancy counter 0..DEPTH.
- Push: `isen`=1 and pre-edge count < DEPTH → write {idTag, srcVal} at tail, tail+1.
- Pop: pre-edge count > 0 and `wrStall`=0 → head entry loaded into oWrTag/oWrVal, oWrEn=1 next cycle, head+1. Otherwise oWrEn=0; oWrTag/oWrVal hold last value.
- Simultaneous push and pop: both occur; count unchanged. Full decision uses pre-edge count only: push while full is rejected even if a pop happens that cycle.
- Rejected push (isen=1, full): entry dropped, flag[3] set.
- Classification on every accepted push, from srcVal: bits[30:0]==0 → flag[0]; exp==8'hFF, frac==0 → flag[1]; exp==8'hFF, frac!=0 → flag[2].
- Flags sticky until `clrFlags` or reset. clrFlags and a new event in the same cycle → that flag ends set (set wins); other flags clear.
- Forwarding: search valid queue entries for tag == lkTag; youngest (nearest tail) match wins. If no queue match and oWrEn=1 with oWrTag==lkTag, hit with oWrVal. No match → oLkHit=0, oLkVal=0. Entry pushed in the current cycle is not visible until after the edge.
- Reset: head=tail=count=0, oWrEn=0, oWrTag=0, oWrVal=0, oFlags=0, oFull=0. Reset mid-operation discards all queued entries with no writes issued; reset overrides push/pop in the same cycle.

## Timing
- Push sampled at edge N; earliest oWrEn high in the cycle after edge N+1 (2-cycle latency, no bypass around the queue).
- Sustained throughput: one push and one pop per cycle; queue never fills at full rate with wrStall low.
- oWrEn is a one-cycle pulse per popped entry; back-to-back entries give consecutive high cycles.
- wrStall affects only the pop decision at the same edge; no extra bubble after stall release.
- oFull, oCount, oFlags are registered; oLkHit/oLkVal purely combinational from state and lkTag.

## Test plan
- Reset then single push idTag=3, srcVal=32'h3F800000 → oWrEn pulse 2 cycles later with oWrTag=3, oWrVal=32'h3F800000; oFlags=0.
- wrStall=1, push 5 results (tags 1..5) → first 4 accepted, oFull=1, oCount=4, flag[3]=1; release stall → tags 1,2,3,4 written on 4 consecutive cycles, tag 5 never.
- Push while full with simultaneous pop → push rejected, count stays DEPTH-1 after edge, flag[3] set.
- Push 32'h80000000, 32'h7F800000, 32'h7FC00000 → oFlags=4'b0111; clrFlags with concurrent push of 32'h00000000 → oFlags=4'b0001.
- wrStall=1, push tag 7 val A then tag 7 val B, lkTag=7 → oLkHit=1, oLkVal=B; lkTag=9 → oLkHit=0, oLkVal=0.
- Queue holding 3 entries, assert reset one cycle → oCount=0, oWrEn stays 0 for following 4 cycles, oFlags=0.

Source files
------------

// File: rtl/fpu_fpf_wbq_if.sv
// Purpose: bundles the push, writeback, lookup and flag signals of the FP writeback queue.
// Latency: none; wiring only.
// Backpressure: upstream watches oFull; the register-file port stalls pops through wrStall.
interface fpu_fpf_wbq_if #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            isen;
    logic [TAGW-1:0] idTag;
    logic [31:0]     srcVal;
    logic            wrStall;
    logic            oWrEn;
    logic [TAGW-1:0] oWrTag;
    logic [31:0]     oWrVal;
    logic            oFull;
    logic [CW-1:0]   oCount;
    logic [TAGW-1:0] lkTag;
    logic            oLkHit;
    logic [31:0]     oLkVal;
    logic            clrFlags;
    logic [3:0]      oFlags;

    // Queue side: consumes pushes, stalls and lookups; produces writes, status and forwarding.
    modport slave (
        input  isen, idTag, srcVal, wrStall, lkTag, clrFlags,
        output oWrEn, oWrTag, oWrVal, oFull, oCount, oLkHit, oLkVal, oFlags
    );

    // Surrounding pipeline side.
    modport master (
        output isen, idTag, srcVal, wrStall, lkTag, clrFlags,
        input  oWrEn, oWrTag, oWrVal, oFull, oCount, oLkHit, oLkVal, oFlags
    );
endinterface

// File: rtl/fpu_fpf_wbq.sv
// Purpose: FIFO between FP multiplier and register-file write port, with sticky flags and tag forwarding.
// Latency: push at edge N gives oWrEn high after edge N+1; one push and one pop per cycle.
// Backpressure: wrStall holds the head entry; pushes while full are dropped and flagged as overrun.
module fpu_fpf_wbq #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic           clk,
    input  logic           reset,
    fpu_fpf_wbq_if.slave   q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TAGW-1:0] tag_mem [DEPTH];
    logic [31:0]     val_mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            wr_en;
    logic [TAGW-1:0] wr_tag;
    logic [31:0]     wr_val;
    logic [3:0]      flags;

    logic            full;
    logic            push_ok;
    logic            pop_ok;
    logic [7:0]      src_exp;
    logic [22:0]     src_frac;
    logic [3:0]      flag_evt;

    // Push/pop decisions use the pre-edge occupancy only, so a pop never frees room for a same-cycle push.
    always_comb begin
        full     = (count == CW'(DEPTH));
        push_ok  = q.isen && !full;
        pop_ok   = (count != '0) && !q.wrStall;
        src_exp  = q.srcVal[30:23];
        src_frac = q.srcVal[22:0];
        flag_evt = '0;
        flag_evt[0] = push_ok && (q.srcVal[30:0] == 31'd0);
        flag_evt[1] = push_ok && (src_exp == 8'hFF) && (src_frac == 23'd0);
        flag_evt[2] = push_ok && (src_exp == 8'hFF) && (src_frac != 23'd0);
        flag_evt[3] = q.isen && full;
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            tag_mem[tail] <= q.idTag;
            val_mem[tail] <= q.srcVal;
        end
    end

    // Pointers, occupancy, write-port registers and sticky flags; reset overrides any push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            wr_en  <= 1'b0;
            wr_tag <= '0;
            wr_val <= '0;
            flags  <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop_ok) begin
                head   <= head + 1'b1;
                wr_tag <= tag_mem[head];
                wr_val <= val_mem[head];
            end
            wr_en <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new event in the clearing cycle still leaves its flag set.
            flags <= (flags & ~{4{q.clrFlags}}) | flag_evt;
        end
    end

    logic            lk_hit;
    logic [31:0]     lk_val;
    logic [PW-1:0]   lk_idx;

    // Forwarding: the in-flight write register is the oldest candidate; queue entries are scanned
    // oldest to youngest so the entry nearest the tail overrides earlier matches.
    always_comb begin
        lk_hit = 1'b0;
        lk_val = '0;
        lk_idx = '0;
        if (wr_en && (wr_tag == q.lkTag)) begin
            lk_hit = 1'b1;
            lk_val = wr_val;
        end
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head + PW'(i);
            if ((CW'(i) < count) && (tag_mem[lk_idx] == q.lkTag)) begin
                lk_hit = 1'b1;
                lk_val = val_mem[lk_idx];
            end
        end
    end

    assign q.oWrEn  = wr_en;
    assign q.oWrTag = wr_tag;
    assign q.oWrVal = wr_val;
    assign q.oFull  = full;
    assign q.oCount = count;
    assign q.oFlags = flags;
    assign q.oLkHit = lk_hit;
    assign q.oLkVal = lk_val;
endmodule

// File: tb/tb_fpu_fpf_wbq.sv
// Purpose: directed self-checking bench for the FP writeback queue.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: exercises wrStall holds, full-queue drops and overrun flagging.
module tb_fpu_fpf_wbq;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    fpu_fpf_wbq_if #(.DEPTH(4), .TAGW(5)) bus ();

    fpu_fpf_wbq #(.DEPTH(4), .TAGW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] t, input logic [31:0] v);
        bus.isen   = 1'b1;
        bus.idTag  = t;
        bus.srcVal = v;
        step();
        bus.isen   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset        = 1'b1;
        bus.isen     = 1'b0;
        bus.idTag    = '0;
        bus.srcVal   = '0;
        bus.wrStall  = 1'b0;
        bus.lkTag    = '0;
        bus.clrFlags = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_count", 32'(bus.oCount), 32'd0);
        chk("rst_wren",  32'(bus.oWrEn),  32'd0);
        chk("rst_flags", 32'(bus.oFlags), 32'd0);
        chk("rst_full",  32'(bus.oFull),  32'd0);
        chk("rst_tag",   32'(bus.oWrTag), 32'd0);

        // Single push: write appears after the second edge.
        push(5'd3, 32'h3F800000);
        chk("p1_wren_n", 32'(bus.oWrEn), 32'd0);
        chk("p1_count",  32'(bus.oCount), 32'd1);
        step();
        chk("p1_wren",  32'(bus.oWrEn),  32'd1);
        chk("p1_tag",   32'(bus.oWrTag), 32'd3);
        chk("p1_val",   bus.oWrVal,      32'h3F800000);
        chk("p1_flags", 32'(bus.oFlags), 32'd0);
        step();
        chk("p1_pulse", 32'(bus.oWrEn), 32'd0);

        // Stalled fill with overflow, then drain in order.
        bus.wrStall = 1'b1;
        for (int i = 1; i <= 5; i++) push(5'(i), 32'h40000000 + 32'(i));
        chk("f_count", 32'(bus.oCount), 32'd4);
        chk("f_full",  32'(bus.oFull),  32'd1);
        chk("f_flags", 32'(bus.oFlags), 32'h8);
        chk("f_wren",  32'(bus.oWrEn),  32'd0);
        bus.wrStall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("d_wren", 32'(bus.oWrEn), 32'd1);
            chk("d_tag",  32'(bus.oWrTag), 32'(i));
            chk("d_val",  bus.oWrVal, 32'h40000000 + 32'(i));
        end
        step();
        chk("d_end_wren",  32'(bus.oWrEn),  32'd0);
        chk("d_end_count", 32'(bus.oCount), 32'd0);
        bus.clrFlags = 1'b1;
        step();
        bus.clrFlags = 1'b0;
        chk("clr_flags", 32'(bus.oFlags), 32'd0);

        // Full queue, push with simultaneous pop: push dropped.
        bus.wrStall = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h41000000 + 32'(i));
        bus.wrStall = 1'b0;
        push(5'd9, 32'h42000000);
        chk("fp_count", 32'(bus.oCount), 32'd3);
        chk("fp_flags", 32'(bus.oFlags), 32'h8);
        chk("fp_tag1",  32'(bus.oWrTag), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("fp_dtag", 32'(bus.oWrTag), 32'(i));
            chk("fp_dval", bus.oWrVal, 32'h41000000 + 32'(i));
        end
        step();
        chk("fp_no9", 32'(bus.oWrEn), 32'd0);
        bus.clrFlags = 1'b1;
        step();
        bus.clrFlags = 1'b0;

        // Classification and set-wins-over-clear.
        push(5'd1, 32'h80000000);
        push(5'd2, 32'h7F800000);
        push(5'd3, 32'h7FC00000);
        chk("cls_flags", 32'(bus.oFlags), 32'h7);
        bus.clrFlags = 1'b1;
        push(5'd4, 32'h00000000);
        bus.clrFlags = 1'b0;
        chk("cls_clr", 32'(bus.oFlags), 32'h1);
        step();
        step();
        step();
        chk("cls_drain", 32'(bus.oCount), 32'd0);

        // Forwarding: youngest match, miss, then writeback-register hit.
        bus.wrStall = 1'b1;
        push(5'd7, 32'h11111111);
        push(5'd7, 32'h22222222);
        bus.lkTag = 5'd7;
        #1;
        chk("lk_hit", 32'(bus.oLkHit), 32'd1);
        chk("lk_val", bus.oLkVal, 32'h22222222);
        bus.lkTag = 5'd9;
        #1;
        chk("lk_miss_hit", 32'(bus.oLkHit), 32'd0);
        chk("lk_miss_val", bus.oLkVal, 32'd0);
        bus.lkTag   = 5'd7;
        bus.wrStall = 1'b0;
        step();
        chk("lk_q_val", bus.oLkVal, 32'h22222222);
        step();
        chk("lk_wb_hit", 32'(bus.oLkHit), 32'd1);
        chk("lk_wb_val", bus.oLkVal, 32'h22222222);
        step();
        chk("lk_gone", 32'(bus.oLkHit), 32'd0);

        // Reset mid-operation discards queued entries.
        bus.wrStall = 1'b1;
        push(5'd1, 32'h00000000);
        push(5'd2, 32'h3F800000);
        push(5'd3, 32'h3F800000);
        chk("mr_pre", 32'(bus.oCount), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.wrStall = 1'b0;
        chk("mr_count", 32'(bus.oCount), 32'd0);
        chk("mr_flags", 32'(bus.oFlags), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mr_wren", 32'(bus.oWrEn), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
